// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA frame engine.
//   - COORD_W / CNT_W: width of ball coordinates and of the timing counters
//   - DEF_*: default 640x480@60 timing and colours used as parameter defaults
//   - BAR_*: colour-bar palette for the optional test pattern (VGA_TESTPAT_EN)
package vga_pkg;

  localparam int COORD_W = 10;
  // One extra bit so ball edge + size never wraps in the pixel compares.
  localparam int CNT_W   = COORD_W + 1;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_BALL_SIZE = 8;

  localparam logic [11:0] DEF_BG_RGB   = 12'h0AF;
  localparam logic [11:0] DEF_BALL_RGB = 12'hF80;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  typedef logic [11:0]        rgb_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // First pipeline stage: flags for one pixel, captured on a pixel tick.
  typedef struct packed {
    logic valid;
    logic act;
    logic hs;
    logic vs;
    logic in_ball;
  } stage1_t;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_frame_engine_if.sv
// vga_frame_engine_if: ball-position handshake from the physics logic.
//   pos_valid : one-clk strobe, capture ball_x/ball_y
//   ball_x    : ball left edge, pixel units
//   ball_y    : ball top edge, line units
// master = physics side (drives), slave = frame engine (samples).
interface vga_frame_engine_if;
  import vga_pkg::*;

  logic   pos_valid;
  coord_t ball_x;
  coord_t ball_y;

  modport master (output pos_valid, output ball_x, output ball_y);
  modport slave  (input  pos_valid, input  ball_x, input  ball_y);

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider and H/V raster counters.
//   clk, reset_n : system clock, async active-low reset
//   tick         : one-clk pixel enable (constantly high when CLK_DIV = 1)
//   h_cnt, v_cnt : current raster position
//   frame_start  : registered pulse the clk after the counters wrap to (0,0)
//   act_raw      : current position is inside the visible area
//   hs_raw       : current column is inside the hsync window
//   vs_raw       : current line is inside the vsync window
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic frame_start,
  output logic act_raw,
  output logic hs_raw,
  output logic vs_raw
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
  // Keep the divider at least one bit wide so CLK_DIV = 1 still elaborates.
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;

  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Registered so the pulse lands on the clk after the wrapping tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_start <= 1'b0;
    else          frame_start <= tick & h_last & v_last;
  end

  assign act_raw = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs_raw  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END));
  assign vs_raw  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END));

endmodule

// File: rtl/vga_frame_engine.sv
// vga_frame_engine: VGA raster engine drawing a square ball on a flat
// background, with tear-free position updates and a 2-tick pixel pipeline.
//   clk, reset_n : system clock, async active-low reset
//   pos          : vga_frame_engine_if.slave, ball position strobe
//   test_mode    : colour-bar select (only with VGA_TESTPAT_EN)
//   rgb          : registered 4:4:4 pixel colour
//   hsync, vsync : sync pulses, active level SYNC_POL, aligned with rgb
//   video_on     : active-video flag aligned with rgb
//   frame_start  : one-clk pulse when the raster wraps to (0,0)
// Optional feature: define VGA_TESTPAT_EN to enable 8 vertical colour bars
// when test_mode = 1 (ball suppressed, sync unchanged).
module vga_frame_engine
  import vga_pkg::*;
#(
  parameter int          CLK_DIV   = DEF_CLK_DIV,
  parameter int          H_ACTIVE  = DEF_H_ACTIVE,
  parameter int          H_FP      = DEF_H_FP,
  parameter int          H_SYNC    = DEF_H_SYNC,
  parameter int          H_BP      = DEF_H_BP,
  parameter int          V_ACTIVE  = DEF_V_ACTIVE,
  parameter int          V_FP      = DEF_V_FP,
  parameter int          V_SYNC    = DEF_V_SYNC,
  parameter int          V_BP      = DEF_V_BP,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int          BALL_SIZE = DEF_BALL_SIZE,
  parameter logic [11:0] BG_RGB    = DEF_BG_RGB,
  parameter logic [11:0] BALL_RGB  = DEF_BALL_RGB
) (
  input  logic                     clk,
  input  logic                     reset_n,
  vga_frame_engine_if.slave        pos,
  input  logic                     test_mode,
  output rgb_t                     rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     video_on,
  output logic                     frame_start
);

  logic    tick;
  cnt_t    h_cnt;
  cnt_t    v_cnt;
  logic    act_raw;
  logic    hs_raw;
  logic    vs_raw;
  logic    commit;
  logic    in_ball_raw;
  cnt_t    bx_lo, bx_hi, by_lo, by_hi;
  pos_t    pending_pos;
  pos_t    active_pos;
  stage1_t s1;
  rgb_t    pix_colour;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .act_raw     (act_raw),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw)
  );

  // The drawn position only changes at vblank start, so a frame never tears.
  // A strobe on the commit clk still lands in pending and waits a frame.
  assign commit = tick && (h_cnt == '0) && (v_cnt == CNT_W'(V_ACTIVE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_pos <= '0;
      active_pos  <= '0;
    end else begin
      if (pos.pos_valid) pending_pos <= '{x: pos.ball_x, y: pos.ball_y};
      if (commit)        active_pos  <= pending_pos;
    end
  end

  // Compares run on CNT_W bits so edge + size cannot wrap back to column 0;
  // anything past the visible area is simply clipped by act.
  assign bx_lo = {1'b0, active_pos.x};
  assign by_lo = {1'b0, active_pos.y};
  assign bx_hi = bx_lo + CNT_W'(BALL_SIZE);
  assign by_hi = by_lo + CNT_W'(BALL_SIZE);

  assign in_ball_raw = (h_cnt >= bx_lo) && (h_cnt < bx_hi) &&
                       (v_cnt >= by_lo) && (v_cnt < by_hi);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
    end else if (tick) begin
      s1 <= '{valid: 1'b1, act: act_raw, hs: hs_raw, vs: vs_raw, in_ball: in_ball_raw};
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam bit HA_POW2 = (H_ACTIVE >= 8) && ((H_ACTIVE & (H_ACTIVE - 1)) == 0);

  logic [2:0] bar_raw;
  logic [2:0] s1_bar;

  // Bar index = h*8/H_ACTIVE: the top three column bits for a power-of-2
  // width, otherwise the number of bar boundaries already passed.
  if (HA_POW2) begin : g_bar_bits
    localparam int HA_LOG2 = $clog2(H_ACTIVE);
    assign bar_raw = h_cnt[HA_LOG2-1 -: 3];
  end else begin : g_bar_cmp
    always_comb begin
      bar_raw = 3'd0;
      for (int i = 1; i < 8; i++) begin
        if ({h_cnt, 3'b000} >= (CNT_W + 3)'(i * H_ACTIVE)) bar_raw = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  s1_bar <= 3'd0;
    else if (tick) s1_bar <= bar_raw;
  end
`else
  // Without the test pattern test_mode has no effect.
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  always_comb begin
    pix_colour = '0;
    if (s1.act) begin
      pix_colour = s1.in_ball ? BALL_RGB : BG_RGB;
`ifdef VGA_TESTPAT_EN
      if (test_mode) pix_colour = bar_colour(s1_bar);
`endif
    end
  end

  // Stage 1 is empty for the first tick after reset; outputs keep their
  // reset values until it holds a real pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb      <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
    end else if (tick && s1.valid) begin
      rgb      <= pix_colour;
      hsync    <= s1.hs ? SYNC_POL : ~SYNC_POL;
      vsync    <= s1.vs ? SYNC_POL : ~SYNC_POL;
      video_on <= s1.act;
    end
  end

endmodule

// File: tb/tb_vga_frame_engine.sv
// tb_vga_frame_engine: randomized self-checking bench for vga_frame_engine.
// Uses a shrunken raster so many frames fit in a short run. The reference
// model derives every output from the number of clock edges since reset
// release and the log of position strobes. Define VGA_TESTPAT_EN to also
// cover the colour-bar mode.
module tb_vga_frame_engine;
  import vga_pkg::*;

  localparam int          CLK_DIV   = 3;
  localparam int          H_ACTIVE  = 32;
  localparam int          H_FP      = 2;
  localparam int          H_SYNC    = 4;
  localparam int          H_BP      = 2;
  localparam int          V_ACTIVE  = 16;
  localparam int          V_FP      = 2;
  localparam int          V_SYNC    = 2;
  localparam int          V_BP      = 2;
  localparam logic        SYNC_POL  = 1'b0;
  localparam int          BALL_SIZE = 4;
  localparam logic [11:0] BG_RGB    = 12'h0AF;
  localparam logic [11:0] BALL_RGB  = 12'hF80;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FL = HT * VT;
  localparam int FRAME_CLKS = FL * CLK_DIV;
  localparam logic [15:0] RESET_VEC = {12'h000, ~SYNC_POL, ~SYNC_POL, 2'b00};

`ifdef VGA_TESTPAT_EN
  localparam bit TP = 1'b1;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
`else
  localparam bit TP = 1'b0;
`endif

  typedef struct {
    int e;
    int x;
    int y;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        test_mode;
  logic [11:0] rgb;
  logic        hsync, vsync, video_on, frame_start;

  vga_frame_engine_if pos_if ();

  vga_frame_engine #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
    .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .V_BP(V_BP), .SYNC_POL(SYNC_POL), .BALL_SIZE(BALL_SIZE),
    .BG_RGB(BG_RGB), .BALL_RGB(BALL_RGB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pos         (pos_if),
    .test_mode   (test_mode),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int      tests = 0;
  int      fails = 0;
  int      edge_cnt = 0;
  bit      checking = 1'b0;
  strobe_t strobes[$];

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask

  // Edge log: edge N is the Nth rising edge with reset released.
  always @(posedge clk) begin
    if (!reset_n) begin
      edge_cnt = 0;
      strobes.delete();
    end else begin
      edge_cnt++;
      if (pos_if.pos_valid)
        strobes.push_back('{e: edge_cnt, x: int'(pos_if.ball_x), y: int'(pos_if.ball_y)});
    end
  end

  // Reference: after k pixel ticks the outputs show raster pixel k-2. Frame f
  // draws the last strobe taken strictly before the vblank-start tick of f-1.
  function automatic logic [15:0] modelVec();
    int k, p, h, v, f, bx, by, ec;
    logic act, hs, vs, fs, in_b;
    logic [11:0] c;
    if (!reset_n) return RESET_VEC;
    k  = edge_cnt / CLK_DIV;
    fs = (edge_cnt > 0) && (edge_cnt % CLK_DIV == 0) && (k % FL == 0);
    if (k < 2) return {12'h000, ~SYNC_POL, ~SYNC_POL, 1'b0, fs};
    p = k - 2;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FL;
    bx = 0;
    by = 0;
    if (f > 0) begin
      ec = CLK_DIV * ((f - 1) * FL + V_ACTIVE * HT + 1);
      foreach (strobes[i]) begin
        if (strobes[i].e < ec) begin
          bx = strobes[i].x;
          by = strobes[i].y;
        end
      end
    end
    act  = (h < H_ACTIVE) && (v < V_ACTIVE);
    hs   = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    vs   = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    in_b = (h >= bx) && (h < bx + BALL_SIZE) && (v >= by) && (v < by + BALL_SIZE);
    c = !act ? 12'h000 : (in_b ? BALL_RGB : BG_RGB);
`ifdef VGA_TESTPAT_EN
    if (act && test_mode) c = BARS[h * 8 / H_ACTIVE];
`endif
    return {c, hs ? SYNC_POL : ~SYNC_POL, vs ? SYNC_POL : ~SYNC_POL, act, fs};
  endfunction

  always @(negedge clk) begin
    if (checking)
      checkOutput("pix", {rgb, hsync, vsync, video_on, frame_start}, modelVec());
  end

  function automatic int commitEdge(input int f);
    return CLK_DIV * (f * FL + V_ACTIVE * HT + 1);
  endfunction

  function automatic int nextCommit(input int margin);
    int f;
    f = (edge_cnt / CLK_DIV) / FL;
    while (commitEdge(f) <= edge_cnt + margin) f++;
    return commitEdge(f);
  endfunction

  // Random traffic: prob is the per-clk strobe chance in percent.
  task automatic applyStimulus(input int cycles, input int prob);
    repeat (cycles) begin
      @(negedge clk);
      #1;
      pos_if.pos_valid = ($urandom_range(0, 99) < prob);
      if ($urandom_range(0, 3) == 0) begin
        pos_if.ball_x = 10'($urandom_range(0, 1023));
        pos_if.ball_y = 10'($urandom_range(0, 1023));
      end else begin
        pos_if.ball_x = 10'($urandom_range(0, H_ACTIVE + 2));
        pos_if.ball_y = 10'($urandom_range(0, V_ACTIVE + 2));
      end
      if (!TP) test_mode = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    #1;
    pos_if.pos_valid = 1'b0;
  endtask

  // Leaves the bench just after the negedge that follows edge 'target'.
  task automatic waitEdge(input int target);
    int guard = 0;
    while (edge_cnt != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checkOutput("wait_edge", 16'(edge_cnt), 16'(target));
  endtask

  // Presents one strobe so it is sampled exactly at edge 'target'.
  task automatic strobeAt(input int target, input int x, input int y);
    waitEdge(target - 1);
    pos_if.pos_valid = 1'b1;
    pos_if.ball_x    = 10'(x);
    pos_if.ball_y    = 10'(y);
    @(negedge clk);
    #1;
    pos_if.pos_valid = 1'b0;
  endtask

  task automatic midFrameReset(input logic tm);
    int f;
    f = (edge_cnt / CLK_DIV) / FL + 1;
    waitEdge(CLK_DIV * (f * FL + 10 * HT + 20));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst", {rgb, hsync, vsync, video_on, frame_start}, RESET_VEC);
    test_mode = tm;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int ce;
    reset_n          = 1'b0;
    test_mode        = 1'b0;
    pos_if.pos_valid = 1'b0;
    pos_if.ball_x    = '0;
    pos_if.ball_y    = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset", {rgb, hsync, vsync, video_on, frame_start}, RESET_VEC);
    checking = 1'b1;
    reset_n  = 1'b1;

    // Mid-frame update: frame 0 keeps (0,0), frame 1 shows (10,8).
    strobeAt(CLK_DIV * (5 * HT + 10), 10, 8);
    applyStimulus(2 * FRAME_CLKS, 0);

    // Ball hanging over the bottom-right corner is clipped, no wrap.
    strobeAt(nextCommit(100) - 60, 30, 14);
    applyStimulus(2 * FRAME_CLKS, 0);

    // Strobe on the commit clk waits one more frame.
    ce = nextCommit(400);
    strobeAt(ce - 200, 5, 5);
    strobeAt(ce, 20, 10);
    applyStimulus(2 * FRAME_CLKS, 0);

    applyStimulus(6 * FRAME_CLKS, 3);

    // Reset in the middle of the active area restarts the raster.
    midFrameReset(1'b0);
    strobeAt(CLK_DIV * (3 * HT), 7, 3);
    applyStimulus(2 * FRAME_CLKS + 100, 0);

    if (TP) begin
      midFrameReset(1'b1);
      strobeAt(CLK_DIV * (3 * HT), 12, 4);
      applyStimulus(2 * FRAME_CLKS + 100, 0);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
